apac_lane_scheduler: RTL and testbench
======================================

// Module: apac_lane_scheduler
// PURPOSE
//  Shares one PIN checker and the gate sequencing of the parking access controller between two entry lanes (A, B).
//  Arbitrates lane requests round-robin, runs PIN verification for the granted lane, sequences that lane's gate,
//  tracks lot occupancy and refuses entry while the lot is full. Sits between the lane sensors/keypads and the gate actuators.
// PARAMETERS
//  PW_W          8         PIN width
//  PSWD          8'h57     correct PIN (8'b0101_0111)
//  MAX_TRIES     3         wrong attempts before lockout
//  CAPACITY      16        lot capacity; OCC_W = $clog2(CAPACITY+1)
//  OPEN_TIMEOUT  64        cycles in OPEN without a pass before forced close; TMR_W = $clog2(OPEN_TIMEOUT+1)
// PORTS
//  clk          in   1      clock; all logic on rising edge
//  rst          in   1      synchronous, active-high reset
//  req_a/req_b  in   1      lane entry sensor (car waiting at lane)
//  pass_a/pass_b in  1      lane post-gate sensor (car crossing)
//  try_a/try_b  in   1      keypad submit; an attempt is its rising edge
//  pin_a/pin_b  in   PW_W   keypad value, sampled on the try rising edge
//  exit_evt     in   1      car left lot (one pulse = one car)
//  grant_a/grant_b out 1    lane owns the checker
//  open_a/open_b   out 1    open that lane's gate
//  close_a/close_b out 1    = ~open_x (gate held closed)
//  alarm_pin    out  1      wrong-PIN lockout active
//  alarm_block  out  1      tailgate/blocking alarm active
//  full         out  1      occupancy == CAPACITY
//  occupancy    out  OCC_W  cars inside
// BEHAVIOUR
//  Reset: state=IDLE; grant_*, open_*, alarm_*, full = 0; close_* = 1; occupancy = 0; tries = 0; last_served = B.
//  All outputs are registered and reflect the state one cycle after the deciding edge.
//  States: IDLE, CHECK, OPEN, LOCK, BLOCK.
//  IDLE: if !full and exactly one req -> CHECK, grant that lane. Both req -> grant the lane != last_served.
//    While full no grant is issued; requests wait.
//  CHECK (owner lane L): on try_L rising edge, compare pin_L with PSWD.
//    Match -> OPEN; tries = 0. Mismatch -> tries+1; if tries reaches MAX_TRIES -> LOCK.
//    req_L falls -> IDLE; tries = 0; last_served = L.
//    req_L & pass_L both high -> BLOCK; this takes priority over a same-cycle try.
//    The non-owner lane's try/pin are ignored.
//  OPEN: open_L = 1; timer counts from 0.
//    pass_L rising edge -> occupancy+1; then IDLE with open_L = 0; last_served = L.
//    Timer == OPEN_TIMEOUT-1 without a pass -> IDLE; no increment.
//  LOCK: alarm_pin = 1; grant kept. A correct PIN on try_L -> IDLE; alarm clears; tries = 0.
//    Wrong PIN -> stay. Only rst also clears LOCK.
//  BLOCK: alarm_block = 1; gate closed. A correct PIN on try_L -> IDLE; wrong PIN -> stay.
//  exit_evt: occupancy-1 in any state, saturating at 0.
//    pass increment and exit_evt in the same cycle -> occupancy unchanged.
//    Increment never exceeds CAPACITY, because no grant is given while full.
//  full is recomputed from the next occupancy value, so it updates in the same cycle as occupancy.
//  Try edge detect: per-lane try_q register; rising = try & ~try_q. A held try counts once.
//  rst asserted mid-operation (any state) -> reset values next cycle; the gate closes immediately.
//  Exactly one of grant_a/grant_b may be high. open_x implies grant_x.
// STRUCTURE
//  apac_pkg: state enum/localparams (IDLE=0..BLOCK=4), PSWD default, MAX_TRIES default.
//  Sub-module apac_pin_checker: try edge detect, PIN compare, attempt counter.
//    Outputs pin_ok, pin_bad, tries_exhausted as 1-cycle pulses.
//  Top: arbiter, FSM, open timer, occupancy counter.
// TESTING
//  1 Basic: rst; req_a=1; try_a edge with pin 8'h57 -> grant_a then open_a.
//    pass_a pulse -> occupancy 1, open_a=0, state IDLE.
//  2 Round-robin: req_a=req_b=1 simultaneously after reset -> grant_a.
//    After A completes -> grant_b, with req_a held high.
//  3 Retries: pins 8'h5F, 8'h5F, 8'h57 -> no alarm_pin, open_a on the third attempt.
//    Holding try high for 5 cycles counts one attempt.
//  4 Lockout: 3 x 8'h5F -> alarm_pin=1. A further 8'h5F keeps it. 8'h57 clears it -> IDLE.
//  5 Block: in CHECK raise req_a & pass_a -> alarm_block=1. Correct PIN -> clears.
//    rst mid-BLOCK -> all outputs at reset values next cycle.
//  6 Capacity: CAPACITY=2; admit 2 cars -> full=1; req_b gets no grant.
//    exit_evt -> full=0, grant_b issued. exit_evt at occupancy 0 -> stays 0.
//    pass + exit in the same cycle -> unchanged. No pass for OPEN_TIMEOUT cycles -> gate closes, no count.

Source files
------------

// File: rtl/apac_pkg.sv
// Shared constants for the parking access controller lane scheduler:
// FSM state encodings, lane identifiers and default PIN/lockout settings.
package apac_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_OPEN  = 3'd2;
    localparam logic [2:0] ST_LOCK  = 3'd3;
    localparam logic [2:0] ST_BLOCK = 3'd4;

    localparam logic LANE_A = 1'b0;
    localparam logic LANE_B = 1'b1;

    localparam logic [7:0] PSWD_DEFAULT      = 8'h57;
    localparam int         MAX_TRIES_DEFAULT = 3;

endpackage

// File: rtl/apac_pin_checker.sv
// Shared PIN checker: per-lane keypad edge detect, PIN compare for the owning
// lane and the wrong-attempt counter. Result outputs are single-cycle pulses.
module apac_pin_checker
    import apac_pkg::*;
#(
    parameter int              PW_W      = 8,
    parameter logic [PW_W-1:0] PSWD      = PW_W'(PSWD_DEFAULT),
    parameter int              MAX_TRIES = MAX_TRIES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            try_a,
    input  logic            try_b,
    input  logic [PW_W-1:0] pin_a,
    input  logic [PW_W-1:0] pin_b,
    input  logic            sel_b,
    input  logic            active,
    input  logic            count_en,
    input  logic            clr_tries,
    output logic            pin_ok,
    output logic            pin_bad,
    output logic            tries_exhausted
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    logic             try_a_q;
    logic             try_b_q;
    logic [TRY_W-1:0] tries_q;
    logic [TRY_W-1:0] tries_d;
    logic             try_rise;
    logic [PW_W-1:0]  pin_sel;

    // Only the owning lane's keypad is looked at; the other lane is ignored.
    always_comb begin
        try_rise        = sel_b ? (try_b & ~try_b_q) : (try_a & ~try_a_q);
        pin_sel         = sel_b ? pin_b : pin_a;
        pin_ok          = active & try_rise & (pin_sel == PSWD);
        pin_bad         = active & try_rise & (pin_sel != PSWD);
        tries_exhausted = count_en & pin_bad & (tries_q == TRY_W'(MAX_TRIES - 1));
        tries_d         = tries_q;
        if (clr_tries || pin_ok) begin
            tries_d = '0;
        end else if (count_en && pin_bad && (tries_q != TRY_W'(MAX_TRIES))) begin
            tries_d = tries_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            try_a_q <= 1'b0;
            try_b_q <= 1'b0;
            tries_q <= '0;
        end else begin
            try_a_q <= try_a;
            try_b_q <= try_b;
            tries_q <= tries_d;
        end
    end

endmodule

// File: rtl/apac_lane_scheduler.sv
// Two-lane parking entry scheduler: round-robin arbitration of one PIN checker,
// gate sequencing with open timeout, occupancy tracking and full-lot refusal.
module apac_lane_scheduler
    import apac_pkg::*;
#(
    parameter int              PW_W         = 8,
    parameter logic [PW_W-1:0] PSWD         = PW_W'(PSWD_DEFAULT),
    parameter int              MAX_TRIES    = MAX_TRIES_DEFAULT,
    parameter int              CAPACITY     = 16,
    parameter int              OPEN_TIMEOUT = 64,
    localparam int             OCC_W        = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             pass_a,
    input  logic             pass_b,
    input  logic             try_a,
    input  logic             try_b,
    input  logic [PW_W-1:0]  pin_a,
    input  logic [PW_W-1:0]  pin_b,
    input  logic             exit_evt,
    output logic             grant_a,
    output logic             grant_b,
    output logic             open_a,
    output logic             open_b,
    output logic             close_a,
    output logic             close_b,
    output logic             alarm_pin,
    output logic             alarm_block,
    output logic             full,
    output logic [OCC_W-1:0] occupancy
);

    localparam int TMR_W = $clog2(OPEN_TIMEOUT + 1);

    logic [2:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             pass_a_q, pass_b_q;
    logic             grant_a_q, grant_a_d, grant_b_q, grant_b_d;
    logic             open_a_q, open_a_d, open_b_q, open_b_d;
    logic             alarm_pin_q, alarm_pin_d, alarm_block_q, alarm_block_d;
    logic             full_q, full_d;
    logic             cur_req, cur_pass, cur_pass_rise, inc;
    logic             pin_ok, pin_bad, tries_exhausted;

    apac_pin_checker #(
        .PW_W      (PW_W),
        .PSWD      (PSWD),
        .MAX_TRIES (MAX_TRIES)
    ) u_pin_checker (
        .clk             (clk),
        .rst             (rst),
        .try_a           (try_a),
        .try_b           (try_b),
        .pin_a           (pin_a),
        .pin_b           (pin_b),
        .sel_b           (owner_q),
        .active          ((state_q == ST_CHECK) || (state_q == ST_LOCK) || (state_q == ST_BLOCK)),
        .count_en        (state_q == ST_CHECK),
        .clr_tries       (state_q == ST_IDLE),
        .pin_ok          (pin_ok),
        .pin_bad         (pin_bad),
        .tries_exhausted (tries_exhausted)
    );

    always_comb begin
        cur_req       = owner_q ? req_b : req_a;
        cur_pass      = owner_q ? pass_b : pass_a;
        cur_pass_rise = owner_q ? (pass_b & ~pass_b_q) : (pass_a & ~pass_a_q);
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        timer_d       = timer_q;
        case (state_q)
            ST_IDLE: begin
                // A full lot leaves requests waiting; a tie goes to the lane not served last.
                if (!full_q) begin
                    if (req_a && req_b) begin
                        owner_d = ~last_q;
                        state_d = ST_CHECK;
                    end else if (req_a) begin
                        owner_d = LANE_A;
                        state_d = ST_CHECK;
                    end else if (req_b) begin
                        owner_d = LANE_B;
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (!cur_req) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end else if (cur_pass) begin
                    state_d = ST_BLOCK;
                end else if (pin_ok) begin
                    state_d = ST_OPEN;
                    timer_d = '0;
                end else if (tries_exhausted) begin
                    state_d = ST_LOCK;
                end
            end
            ST_OPEN: begin
                if (cur_pass_rise) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end else if (timer_q == TMR_W'(OPEN_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_LOCK, ST_BLOCK: begin
                if (pin_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A same-cycle entry and exit cancel out; exits saturate at an empty lot.
        inc   = (state_q == ST_OPEN) && cur_pass_rise && (occ_q != OCC_W'(CAPACITY));
        occ_d = occ_q;
        if (inc && exit_evt) begin
            occ_d = occ_q;
        end else if (inc) begin
            occ_d = occ_q + 1'b1;
        end else if (exit_evt && (occ_q != '0)) begin
            occ_d = occ_q - 1'b1;
        end

        grant_a_d     = (state_d != ST_IDLE) && (owner_d == LANE_A);
        grant_b_d     = (state_d != ST_IDLE) && (owner_d == LANE_B);
        open_a_d      = (state_d == ST_OPEN) && (owner_d == LANE_A);
        open_b_d      = (state_d == ST_OPEN) && (owner_d == LANE_B);
        alarm_pin_d   = (state_d == ST_LOCK);
        alarm_block_d = (state_d == ST_BLOCK);
        full_d        = (occ_d == OCC_W'(CAPACITY));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= LANE_A;
            last_q        <= LANE_B;
            timer_q       <= '0;
            occ_q         <= '0;
            pass_a_q      <= 1'b0;
            pass_b_q      <= 1'b0;
            grant_a_q     <= 1'b0;
            grant_b_q     <= 1'b0;
            open_a_q      <= 1'b0;
            open_b_q      <= 1'b0;
            alarm_pin_q   <= 1'b0;
            alarm_block_q <= 1'b0;
            full_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            timer_q       <= timer_d;
            occ_q         <= occ_d;
            pass_a_q      <= pass_a;
            pass_b_q      <= pass_b;
            grant_a_q     <= grant_a_d;
            grant_b_q     <= grant_b_d;
            open_a_q      <= open_a_d;
            open_b_q      <= open_b_d;
            alarm_pin_q   <= alarm_pin_d;
            alarm_block_q <= alarm_block_d;
            full_q        <= full_d;
        end
    end

    assign grant_a     = grant_a_q;
    assign grant_b     = grant_b_q;
    assign open_a      = open_a_q;
    assign open_b      = open_b_q;
    assign close_a     = ~open_a_q;
    assign close_b     = ~open_b_q;
    assign alarm_pin   = alarm_pin_q;
    assign alarm_block = alarm_block_q;
    assign full        = full_q;
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_apac_lane_scheduler.sv
// Directed bench for apac_lane_scheduler with a two-car lot: admission,
// round-robin, retries, lockout, tailgate block, capacity and gate timeout.
module tb_apac_lane_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b, pass_a, pass_b, try_a, try_b, exit_evt;
    logic [7:0] pin_a, pin_b;
    logic       grant_a, grant_b, open_a, open_b, close_a, close_b;
    logic       alarm_pin, alarm_block, full;
    logic [1:0] occupancy;
    int         total_checks = 0;
    int         bad_checks   = 0;

    apac_lane_scheduler #(
        .CAPACITY     (2),
        .OPEN_TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_a       (req_a),
        .req_b       (req_b),
        .pass_a      (pass_a),
        .pass_b      (pass_b),
        .try_a       (try_a),
        .try_b       (try_b),
        .pin_a       (pin_a),
        .pin_b       (pin_b),
        .exit_evt    (exit_evt),
        .grant_a     (grant_a),
        .grant_b     (grant_b),
        .open_a      (open_a),
        .open_b      (open_b),
        .close_a     (close_a),
        .close_b     (close_b),
        .alarm_pin   (alarm_pin),
        .alarm_block (alarm_block),
        .full        (full),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1ns past the last one before sampling.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req_a = 0; req_b = 0; pass_a = 0; pass_b = 0;
        try_a = 0; try_b = 0; exit_evt = 0; pin_a = 8'h00; pin_b = 8'h00;
        applyStimulus(2);
        rst = 1'b0;
        checkOutput("rst_grant", {grant_a, grant_b}, 2'b00);
        checkOutput("rst_gate", {open_a, open_b, close_a, close_b}, 4'b0011);
        checkOutput("rst_alarm", {alarm_pin, alarm_block, full}, 3'b000);
        checkOutput("rst_occ", occupancy, 0);

        // Basic admission on lane A.
        req_a = 1; applyStimulus(1);
        checkOutput("t1_grant", {grant_a, grant_b, open_a}, 3'b100);
        pin_a = 8'h57; try_a = 1; applyStimulus(1);
        checkOutput("t1_open", {open_a, close_a, grant_a}, 3'b101);
        try_a = 0; pass_a = 1; applyStimulus(1);
        checkOutput("t1_pass", {open_a, grant_a, close_a}, 3'b001);
        checkOutput("t1_occ", occupancy, 1);
        pass_a = 0; req_a = 0; exit_evt = 1; applyStimulus(1);
        exit_evt = 0;
        checkOutput("t1_exit", occupancy, 0);

        // Round-robin and capacity.
        rst = 1; applyStimulus(1); rst = 0;
        req_a = 1; req_b = 1; applyStimulus(1);
        checkOutput("t2_tie", {grant_a, grant_b}, 2'b10);
        try_a = 1; applyStimulus(1);
        try_a = 0; pass_a = 1; applyStimulus(1);
        pass_a = 0; applyStimulus(1);
        checkOutput("t2_rr", {grant_a, grant_b}, 2'b01);
        pin_b = 8'h57; try_b = 1; applyStimulus(1);
        checkOutput("t2_openb", {open_b, close_b, open_a}, 3'b100);
        try_b = 0; pass_b = 1; applyStimulus(1);
        checkOutput("t2_full", {full, occupancy}, 3'b110);
        pass_b = 0; req_a = 0; applyStimulus(1);
        checkOutput("t2_nogrant", {grant_a, grant_b}, 2'b00);
        exit_evt = 1; applyStimulus(1);
        exit_evt = 0;
        checkOutput("t2_exit", {full, occupancy, grant_b}, 4'b0010);
        applyStimulus(1);
        checkOutput("t2_grantb", {grant_a, grant_b}, 2'b01);
        req_b = 0; applyStimulus(1);
        checkOutput("t2_reqfall", grant_b, 0);
        exit_evt = 1; applyStimulus(1);
        checkOutput("t2_occ0", occupancy, 0);
        applyStimulus(1);
        exit_evt = 0;
        checkOutput("t2_sat0", occupancy, 0);

        // Retries with a held keypad, then open timeout without a pass.
        req_a = 1; applyStimulus(1);
        pin_a = 8'h5F; try_a = 1; applyStimulus(5);
        try_a = 0; applyStimulus(1);
        try_a = 1; applyStimulus(1);
        try_a = 0; applyStimulus(1);
        checkOutput("t3_two_bad", {alarm_pin, grant_a, open_a}, 3'b010);
        pin_a = 8'h57; try_a = 1; applyStimulus(1);
        try_a = 0;
        checkOutput("t3_open", {open_a, alarm_pin}, 2'b10);
        applyStimulus(63);
        checkOutput("t3_still_open", open_a, 1);
        applyStimulus(1);
        checkOutput("t3_timeout", {open_a, close_a, grant_a, occupancy}, 5'b01000);
        req_a = 0; applyStimulus(1);

        // Lockout after three wrong PINs.
        req_a = 1; applyStimulus(1);
        pin_a = 8'h5F;
        for (int i = 0; i < 3; i++) begin
            try_a = 1; applyStimulus(1);
            try_a = 0; applyStimulus(1);
            checkOutput($sformatf("t4_try%0d", i), alarm_pin, (i == 2) ? 1 : 0);
        end
        checkOutput("t4_grant", grant_a, 1);
        try_a = 1; applyStimulus(1);
        try_a = 0; applyStimulus(1);
        checkOutput("t4_stay", alarm_pin, 1);
        pin_a = 8'h57; try_a = 1; applyStimulus(1);
        try_a = 0;
        checkOutput("t4_clear", {alarm_pin, grant_a}, 2'b00);
        req_a = 0; applyStimulus(1);

        // Tailgate block, recovery, and reset mid-block.
        req_a = 1; applyStimulus(1);
        pass_a = 1; applyStimulus(1);
        checkOutput("t5_block", {alarm_block, open_a, close_a}, 3'b101);
        pass_a = 0; try_a = 1; applyStimulus(1);
        try_a = 0;
        checkOutput("t5_clear", {alarm_block, grant_a}, 2'b00);
        applyStimulus(1);
        pass_a = 1; applyStimulus(1);
        checkOutput("t5_block2", alarm_block, 1);
        rst = 1; applyStimulus(1);
        checkOutput("t5_rst", {grant_a, grant_b, open_a, open_b, close_a, close_b, alarm_pin, alarm_block, full}, 9'b000011000);
        rst = 0; pass_a = 0; applyStimulus(1);

        // Pass and exit on the same edge leave occupancy unchanged.
        try_a = 1; applyStimulus(1);
        try_a = 0;
        checkOutput("t6_open", open_a, 1);
        pass_a = 1; exit_evt = 1; applyStimulus(1);
        checkOutput("t6_same", {occupancy, open_a}, 3'b000);
        pass_a = 0; exit_evt = 0; req_a = 0; applyStimulus(1);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
